// File: rtl/ant_farm_pkg.sv
// Shared types and constants for the ant farm renderer.
// Optional feature macro ANT_WRAP_EN is consumed by ant_sprite_renderer.
`default_nettype none

package ant_farm_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;
  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} fsm_t;
  typedef logic [11:0] rgb_t;

  // Right-shifting Galois step: the bit shifted out feeds back through the mask.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ant_lfsr.sv
// 16-bit Galois LFSR with reset seed; advances one step per cycle while i_step is high.
`default_nettype none

module ant_lfsr
  import ant_farm_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_step,
  output logic [15:0] o_state
);

  always_ff @(posedge i_clk) begin
    if (i_rst)       o_state <= SEED;
    else if (i_step) o_state <= lfsr_next(o_state);
  end

endmodule

`default_nettype wire

// File: rtl/ant_sprite_renderer.sv
// Ant sprite pixel-colour stage: per-frame LFSR random walk plus registered RGB output.
// Define ANT_WRAP_EN to make ants wrap around screen edges instead of clamping.
`default_nettype none

module ant_sprite_renderer
  import ant_farm_pkg::*;
#(
  parameter int          N_ANTS    = 8,
  parameter int          ANT_SIZE  = 4,
  parameter int          STEP      = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter rgb_t        ANT_RGB   = 12'hA52,
  parameter rgb_t        BG_RGB    = 12'h320
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  input  logic       i_active,
  input  logic       i_animate,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  output logic [3:0] o_r,
  output logic [3:0] o_g,
  output logic [3:0] o_b,
  output logic       o_busy
);

  localparam int X_MAX = H_ACTIVE - ANT_SIZE;
  localparam int Y_MAX = V_ACTIVE - ANT_SIZE;
  localparam int IDX_W = (N_ANTS > 1) ? $clog2(N_ANTS) : 1;

  localparam logic [10:0]      STEP_W   = 11'(STEP);
  localparam logic [10:0]      XMAX_W   = 11'(X_MAX);
  localparam logic [10:0]      YMAX_W   = 11'(Y_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ANTS - 1);

  logic [9:0]       ant_x [N_ANTS];
  logic [8:0]       ant_y [N_ANTS];
  fsm_t             state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             anim_q;
  logic             start;
  logic             upd;
  logic [15:0]      lfsr;
  logic             unused_lfsr_bits;
  dir_t             dir;
  logic [10:0]      cur_x, cur_y, new_x, new_y;
  logic             hit;
  rgb_t             pix, rgb;

  function automatic logic [9:0] reset_x(input int k);
    return (64 * (k + 1) > X_MAX) ? 10'(X_MAX) : 10'(64 * (k + 1));
  endfunction

  // Compare before subtracting so a move past 0 never underflows.
  function automatic logic [10:0] move(input logic [10:0] v, input logic [10:0] lim,
                                       input logic inc);
    if (inc) begin
`ifdef ANT_WRAP_EN
      return (v + STEP_W > lim) ? v + STEP_W - lim - 11'd1 : v + STEP_W;
`else
      return (v + STEP_W > lim) ? lim : v + STEP_W;
`endif
    end
`ifdef ANT_WRAP_EN
    return (v >= STEP_W) ? v - STEP_W : v + lim + 11'd1 - STEP_W;
`else
    return (v >= STEP_W) ? v - STEP_W : 11'd0;
`endif
  endfunction

  ant_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_step (upd),
    .o_state(lfsr)
  );

  assign unused_lfsr_bits = ^lfsr[15:2];
  assign dir   = dir_t'(lfsr[1:0]);
  assign start = i_animate & ~anim_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      anim_q <= 1'b0;
      idx    <= '0;
    end else begin
      state  <= state_nxt;
      anim_q <= i_animate;
      if (upd) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // A start edge seen outside IDLE is simply dropped.
  always_comb begin
    state_nxt = state;
    upd       = 1'b0;
    o_busy    = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_UPDATE;
      S_UPDATE: begin
        upd    = 1'b1;
        o_busy = 1'b1;
        if (idx == IDX_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        o_busy    = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign cur_x = {1'b0, ant_x[idx]};
  assign cur_y = {2'b0, ant_y[idx]};

  always_comb begin
    new_x = cur_x;
    new_y = cur_y;
    case (dir)
      DIR_UP:    new_y = move(cur_y, YMAX_W, 1'b0);
      DIR_RIGHT: new_x = move(cur_x, XMAX_W, 1'b1);
      DIR_DOWN:  new_y = move(cur_y, YMAX_W, 1'b1);
      default:   new_x = move(cur_x, XMAX_W, 1'b0);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_ANTS; k++) begin
        ant_x[k] <= reset_x(k);
        ant_y[k] <= 9'(V_ACTIVE / 2);
      end
    end else if (upd) begin
      ant_x[idx] <= new_x[9:0];
      ant_y[idx] <= new_y[8:0];
    end
  end

  // Positions only change during blanking, so a combinational read cannot tear.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < N_ANTS; k++) begin
      if (({1'b0, i_x} >= {1'b0, ant_x[k]}) &&
          ({1'b0, i_x} <  {1'b0, ant_x[k]} + 11'(ANT_SIZE)) &&
          ({1'b0, i_y} >= {1'b0, ant_y[k]}) &&
          ({1'b0, i_y} <  {1'b0, ant_y[k]} + 10'(ANT_SIZE)))
        hit = 1'b1;
    end
  end

  assign pix = !i_active ? rgb_t'(0) : (hit ? ANT_RGB : BG_RGB);

  always_ff @(posedge i_clk) begin
    if (i_rst)          rgb <= '0;
    else if (i_pix_stb) rgb <= pix;
  end

  assign {o_r, o_g, o_b} = rgb;

endmodule

`default_nettype wire

// File: tb/tb_ant_sprite_renderer.sv
// Self-checking bench: default instance plus a 16-ant, STEP=24 instance that reaches the walls.
`timescale 1ns/1ps

module tb_ant_sprite_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, pix_stb, active, animate;
  logic [9:0] x;
  logic [8:0] y;
  logic [3:0] ra, ga, ba, rb, gb, bb;
  logic       busy_a, busy_b;

  ant_sprite_renderer dut (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(pix_stb), .i_active(active),
    .i_animate(animate), .i_x(x), .i_y(y),
    .o_r(ra), .o_g(ga), .o_b(ba), .o_busy(busy_a)
  );

  ant_sprite_renderer #(.N_ANTS(16), .STEP(24)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(pix_stb), .i_active(active),
    .i_animate(animate), .i_x(x), .i_y(y),
    .o_r(rb), .o_g(gb), .o_b(bb), .o_busy(busy_b)
  );

  localparam int XL = 636;
  localparam int YL = 476;

  int total = 0;
  int bad   = 0;

  int nants [2] = '{8, 16};
  int step  [2] = '{2, 24};
  int mx [2][16];
  int my [2][16];
  int mlfsr [2];

  typedef struct {
    bit act;
    int px;
    int py;
    int ea;
    int eb;
  } vec_t;
  vec_t tbl [14];

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mlfsr[i] = 'hACE1;
      for (int k = 0; k < 16; k++) begin
        mx[i][k] = (64 * (k + 1) > XL) ? XL : 64 * (k + 1);
        my[i][k] = 240;
      end
    end
  endtask

  function automatic int go_down(int v, int s, int lim);
`ifdef ANT_WRAP_EN
    return (((v - s) % (lim + 1)) + (lim + 1)) % (lim + 1);
`else
    return (v - s < 0) ? 0 : v - s;
`endif
  endfunction

  function automatic int go_up(int v, int s, int lim);
`ifdef ANT_WRAP_EN
    return (v + s) % (lim + 1);
`else
    return (v + s > lim) ? lim : v + s;
`endif
  endfunction

  task automatic model_frame();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < nants[i]; k++) begin
        case (mlfsr[i] % 4)
          0: my[i][k] = go_down(my[i][k], step[i], YL);
          1: mx[i][k] = go_up  (mx[i][k], step[i], XL);
          2: my[i][k] = go_up  (my[i][k], step[i], YL);
          default: mx[i][k] = go_down(mx[i][k], step[i], XL);
        endcase
        if (mlfsr[i] % 2 == 1) mlfsr[i] = (mlfsr[i] / 2) ^ 'hB400;
        else                   mlfsr[i] = mlfsr[i] / 2;
      end
    end
  endtask

  function automatic int model_rgb(int i, bit act, int px, int py);
    if (!act) return 0;
    for (int k = 0; k < nants[i]; k++)
      if (px >= mx[i][k] && px < mx[i][k] + 4 && py >= my[i][k] && py < my[i][k] + 4)
        return 'hA52;
    return 'h320;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic pix(string name, bit act, int px, int py, int ea, int eb);
    active  = act;
    x       = 10'(px);
    y       = 9'(py);
    pix_stb = 1'b1;
    @(posedge clk); #1;
    pix_stb = 1'b0;
    check({name, "_a"}, int'({ra, ga, ba}), ea);
    check({name, "_b"}, int'({rb, gb, bb}), eb);
  endtask

  task automatic frame(input bit second_rise, output int cnt_a, output int cnt_b);
    cnt_a   = 0;
    cnt_b   = 0;
    animate = 1'b1;
    for (int c = 0; c < 26; c++) begin
      @(posedge clk); #1;
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      if (c == 2) animate = 1'b0;
      if (second_rise && c == 4) animate = 1'b1;
      if (second_rise && c == 6) animate = 1'b0;
    end
  endtask

  task automatic check_pos(string name);
    logic [303:0] act_v, exp_v;
    int oob;
    act_v = '0;
    exp_v = '0;
    oob   = 0;
    for (int k = 0; k < 8; k++) begin
      act_v[k*19 +: 19] = {dut.ant_x[k], dut.ant_y[k]};
      exp_v[k*19 +: 19] = {10'(mx[0][k]), 9'(my[0][k])};
      if (dut.ant_x[k] > 10'(XL) || dut.ant_y[k] > 9'(YL)) oob++;
    end
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s_pos_a: got %h expected %h", name, act_v[151:0], exp_v[151:0]);
    end
    act_v = '0;
    exp_v = '0;
    for (int k = 0; k < 16; k++) begin
      act_v[k*19 +: 19] = {dut_b.ant_x[k], dut_b.ant_y[k]};
      exp_v[k*19 +: 19] = {10'(mx[1][k]), 9'(my[1][k])};
      if (dut_b.ant_x[k] > 10'(XL) || dut_b.ant_y[k] > 9'(YL)) oob++;
    end
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s_pos_b: got %h expected %h", name, act_v, exp_v);
    end
    check({name, "_bounds"}, oob, 0);
    check({name, "_lfsr_a"}, int'(dut.u_lfsr.o_state), mlfsr[0]);
    check({name, "_lfsr_b"}, int'(dut_b.u_lfsr.o_state), mlfsr[1]);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cnt_a, cnt_b, k, px, py;
    bit act;

    tbl[0]  = '{1'b1,  64, 240, 'hA52, 'hA52};
    tbl[1]  = '{1'b1,   0,   0, 'h320, 'h320};
    tbl[2]  = '{1'b1,  67, 243, 'hA52, 'hA52};
    tbl[3]  = '{1'b1,  68, 240, 'h320, 'h320};
    tbl[4]  = '{1'b1,  63, 240, 'h320, 'h320};
    tbl[5]  = '{1'b1,  64, 244, 'h320, 'h320};
    tbl[6]  = '{1'b1, 128, 241, 'hA52, 'hA52};
    tbl[7]  = '{1'b1, 512, 243, 'hA52, 'hA52};
    tbl[8]  = '{1'b1, 576, 240, 'h320, 'hA52};
    tbl[9]  = '{1'b1, 639, 243, 'h320, 'hA52};
    tbl[10] = '{1'b1, 635, 240, 'h320, 'h320};
    tbl[11] = '{1'b0,  64, 240, 'h000, 'h000};
    tbl[12] = '{1'b0, 639, 479, 'h000, 'h000};
    tbl[13] = '{1'b1, 639, 479, 'h320, 'h320};

    rst = 1'b1; pix_stb = 1'b0; active = 1'b0; animate = 1'b0; x = '0; y = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", int'({ra, ga, ba}), 0);
    check("reset_busy", int'(busy_a), 0);
    check_pos("reset");
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      pix($sformatf("tbl%0d", i), tbl[i].act, tbl[i].px, tbl[i].py, tbl[i].ea, tbl[i].eb);

    // Output must hold while the strobe is low, then follow one strobe later.
    active = 1'b1; x = 10'd64; y = 9'd240;
    repeat (3) @(posedge clk);
    #1;
    check("hold_a", int'({ra, ga, ba}), 'h320);
    pix("after_hold", 1'b1, 64, 240, 'hA52, 'hA52);

    // Single frame update with animate held for 3 clocks.
    frame(1'b0, cnt_a, cnt_b);
    check("busy_cycles_a", cnt_a, 9);
    check("busy_cycles_b", cnt_b, 17);
    model_frame();
    check_pos("frame1");

    // A second rise while busy must be ignored.
    frame(1'b1, cnt_a, cnt_b);
    check("busy_retrig_a", cnt_a, 9);
    check("busy_retrig_b", cnt_b, 17);
    model_frame();
    check_pos("retrig");

    // Reset in the middle of an update.
    animate = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", int'(busy_a), 1);
    check("mid_idx", int'(dut.idx), 3);
    rst = 1'b1; animate = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", int'(busy_a), 0);
    check("rst_ant0_x", int'(dut.ant_x[0]), 64);
    check("rst_ant0_y", int'(dut.ant_y[0]), 240);
    check("rst_lfsr", int'(dut.u_lfsr.o_state), 'hACE1);
    rst = 1'b0;
    model_reset();
    check_pos("after_rst");

    // Long random walk: the STEP=24 instance repeatedly reaches every wall.
    for (int f = 0; f < 1000; f++) begin
      frame(1'b0, cnt_a, cnt_b);
      model_frame();
      check_pos($sformatf("f%0d", f));
      k   = $urandom_range(0, 7);
      px  = mx[0][k] + int'($urandom_range(0, 7)) - 2;
      py  = my[0][k] + int'($urandom_range(0, 7)) - 2;
      if (f % 4 == 3) begin
        px = int'($urandom_range(0, 639));
        py = int'($urandom_range(0, 479));
      end
      px  = (px < 0) ? 0 : (px > 639) ? 639 : px;
      py  = (py < 0) ? 0 : (py > 479) ? 479 : py;
      act = ($urandom_range(0, 7) != 0);
      pix($sformatf("rnd%0d", f), act, px, py, model_rgb(0, act, px, py), model_rgb(1, act, px, py));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
